// File: rtl/router_pkg.sv
// router_pkg: shared widths, header field positions and address check for the 1x3 router
package router_pkg;
  localparam int DW_DEF = 8;
  localparam logic [1:0] ADDR_INVALID = 2'b11;
  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 2;
  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  function automatic logic addr_ok(input logic [1:0] a);
    return a != ADDR_INVALID;
  endfunction
endpackage

// File: rtl/router_parity_acc.sv
// router_parity_acc: running XOR over header/payload, captures the trailing parity byte, flags mismatch
module router_parity_acc import router_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          detect_add,
  input  logic          lfd_state,
  input  logic          ld_state,
  input  logic          packet_valid,
  input  logic          full_state,
  input  logic          parity_done,
  input  logic [DW-1:0] header_reg,
  input  logic [DW-1:0] datain,
  output logic          err
);
  logic [DW-1:0] int_parity, pkt_parity;
  // accumulate parity over header and payload bytes accepted by the source
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) int_parity <= '0;
    else int_parity <= detect_add ? '0 :
                       lfd_state ? int_parity ^ header_reg :
                       (ld_state && packet_valid && !full_state) ? int_parity ^ datain : int_parity;
  // the byte seen in LOAD_DATA once packet_valid drops is the packet's parity byte
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) pkt_parity <= '0;
    else if (ld_state && !packet_valid) pkt_parity <= datain;
  // compare one cycle after the parity byte lands, cleared at the next header
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) err <= 1'b0;
    else err <= detect_add ? 1'b0 : parity_done ? (int_parity != pkt_parity) : err;
endmodule

// File: rtl/router_reg.sv
// router_reg: router datapath register block; parity checking built only with ROUTER_REG_PARITY_CHK_EN
module router_reg import router_pkg::*; #(
  parameter int DW = DW_DEF
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          packet_valid,
  input  logic          fifo_full,
  input  logic          detect_add,
  input  logic          ld_state,
  input  logic          laf_state,
  input  logic          full_state,
  input  logic          lfd_state,
  input  logic          rst_int_reg,
  input  logic [DW-1:0] datain,
  output logic [DW-1:0] dout,
  output logic          err,
  output logic          parity_done,
  output logic          low_packet_valid
);
  logic [DW-1:0] header_reg, full_reg;
  // latch the header only when it addresses a real output port
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) header_reg <= '0;
    else if (detect_add && packet_valid && addr_ok(datain[ADDR_MSB:ADDR_LSB])) header_reg <= datain;
  // hold the byte that arrived while the FIFO refused writes
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) full_reg <= '0;
    else if (ld_state && fifo_full) full_reg <= datain;
  // FIFO data bus: header, live payload, or the byte parked during full
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) dout <= '0;
    else dout <= lfd_state ? header_reg :
                 (ld_state && !fifo_full) ? datain :
                 laf_state ? full_reg : dout;
  // remember that packet_valid fell in LOAD_DATA until the FSM clears it
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) low_packet_valid <= 1'b0;
    else low_packet_valid <= rst_int_reg ? 1'b0 : (ld_state && !packet_valid) ? 1'b1 : low_packet_valid;
  // sticky flag for parity byte written, cleared by the next header
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) parity_done <= 1'b0;
    else parity_done <= detect_add ? 1'b0 :
                        ((ld_state && !fifo_full && !packet_valid) ||
                         (laf_state && low_packet_valid && !parity_done)) ? 1'b1 : parity_done;
`ifdef ROUTER_REG_PARITY_CHK_EN
  router_parity_acc #(.DW(DW)) u_parity (
    .clk         (clk),
    .resetn      (resetn),
    .detect_add  (detect_add),
    .lfd_state   (lfd_state),
    .ld_state    (ld_state),
    .packet_valid(packet_valid),
    .full_state  (full_state),
    .parity_done (parity_done),
    .header_reg  (header_reg),
    .datain      (datain),
    .err         (err)
  );
`else
  logic unused_full_state;
  assign unused_full_state = full_state;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg: directed self-checking bench for router_reg
module tb_router_reg;
`ifdef ROUTER_REG_PARITY_CHK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif
  logic clk, resetn, packet_valid, fifo_full, detect_add, ld_state, laf_state;
  logic full_state, lfd_state, rst_int_reg, err, parity_done, low_packet_valid;
  logic [7:0] datain, dout, par, b;
  int compared = 0, mismatched = 0;

  router_reg #(.DW(8)) dut (
    .clk(clk), .resetn(resetn), .packet_valid(packet_valid), .fifo_full(fifo_full),
    .detect_add(detect_add), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .lfd_state(lfd_state), .rst_int_reg(rst_int_reg),
    .datain(datain), .dout(dout), .err(err), .parity_done(parity_done),
    .low_packet_valid(low_packet_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    {packet_valid, fifo_full, detect_add, ld_state, laf_state, full_state, lfd_state, rst_int_reg} = '0;
  endtask

  initial begin
    idle();
    datain = 8'h00;
    resetn = 1'b0;
    #2;
    chk("rst_dout", dout, 8'h00);
    chk("rst_err", {7'd0, err}, 8'h00);
    chk("rst_pd", {7'd0, parity_done}, 8'h00);
    chk("rst_lpv", {7'd0, low_packet_valid}, 8'h00);
    tick();
    resetn = 1'b1;
    tick();
    // good packet, header 0x22, eight payload bytes
    detect_add = 1; packet_valid = 1; datain = 8'h22;
    tick();
    chk("good_hdr_pd", {7'd0, parity_done}, 8'h00);
    idle(); lfd_state = 1; packet_valid = 1; datain = 8'h00;
    tick();
    chk("good_lfd_dout", dout, 8'h22);
    par = 8'h22;
    idle(); ld_state = 1; packet_valid = 1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      datain = b;
      par = par ^ b;
      tick();
      chk("good_payload_dout", dout, b);
    end
    packet_valid = 0; datain = par;
    tick();
    chk("good_par_dout", dout, par);
    chk("good_pd", {7'd0, parity_done}, 8'h01);
    chk("good_lpv", {7'd0, low_packet_valid}, 8'h01);
    idle();
    tick();
    chk("good_err", {7'd0, err}, 8'h00);
    chk("good_pd_sticky", {7'd0, parity_done}, 8'h01);
    // rst_int_reg clears low_packet_valid only
    rst_int_reg = 1;
    tick();
    chk("rstint_lpv", {7'd0, low_packet_valid}, 8'h00);
    chk("rstint_pd", {7'd0, parity_done}, 8'h01);
    // bad parity packet, header 0x21
    idle(); detect_add = 1; packet_valid = 1; datain = 8'h21;
    tick();
    chk("bad_hdr_pd", {7'd0, parity_done}, 8'h00);
    chk("bad_hdr_err", {7'd0, err}, 8'h00);
    idle(); lfd_state = 1; packet_valid = 1;
    tick();
    chk("bad_lfd_dout", dout, 8'h21);
    par = 8'h21;
    idle(); ld_state = 1; packet_valid = 1;
    for (int i = 0; i < 4; i++) begin
      b = 8'h30 + 8'(i * 7);
      datain = b;
      par = par ^ b;
      tick();
      chk("bad_payload_dout", dout, b);
    end
    packet_valid = 0; datain = ~par;
    tick();
    chk("bad_pd", {7'd0, parity_done}, 8'h01);
    chk("bad_err_early", {7'd0, err}, 8'h00);
    idle();
    tick();
    chk("bad_err", {7'd0, err}, {7'd0, PCHK});
    // new header clears parity_done/err; rst_int_reg clears low_packet_valid
    detect_add = 1; packet_valid = 1; rst_int_reg = 1; datain = 8'h22;
    tick();
    chk("clr_pd", {7'd0, parity_done}, 8'h00);
    chk("clr_err", {7'd0, err}, 8'h00);
    chk("clr_lpv", {7'd0, low_packet_valid}, 8'h00);
    // FIFO full during LOAD_DATA, then LOAD_AFTER_FULL
    idle(); lfd_state = 1; packet_valid = 1;
    tick();
    chk("full_lfd_dout", dout, 8'h22);
    idle(); ld_state = 1; packet_valid = 1; datain = 8'h10;
    tick();
    chk("full_pre_dout", dout, 8'h10);
    fifo_full = 1; datain = 8'hA5;
    tick();
    chk("full_hold_dout", dout, 8'h10);
    idle(); laf_state = 1; packet_valid = 1; datain = 8'h00;
    tick();
    chk("laf_dout", dout, 8'hA5);
    chk("laf_pd", {7'd0, parity_done}, 8'h00);
    // invalid address keeps the previous header
    idle(); detect_add = 1; packet_valid = 1; datain = 8'h23;
    tick();
    idle(); lfd_state = 1; packet_valid = 1; datain = 8'h00;
    tick();
    chk("inv_lfd_dout", dout, 8'h22);
    // clears win over simultaneous set conditions
    idle(); ld_state = 1; detect_add = 1; rst_int_reg = 1; datain = 8'h77;
    tick();
    chk("prio_pd", {7'd0, parity_done}, 8'h00);
    chk("prio_lpv", {7'd0, low_packet_valid}, 8'h00);
    // asynchronous reset mid-packet
    idle(); ld_state = 1; packet_valid = 1; datain = 8'h5A;
    tick();
    chk("mid_dout", dout, 8'h5A);
    resetn = 1'b0;
    #1;
    chk("mid_rst_dout", dout, 8'h00);
    tick();
    resetn = 1'b1;
    idle(); lfd_state = 1;
    tick();
    chk("post_rst_hdr", dout, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
